uart_rx_oversample: RTL and testbench

16x-oversampling UART receive front end that sits directly upstream of fifo_buffer. It converts the asynchronous rxd line into 8-bit words written through the we/full handshake. It adds input synchronisation, a 3-sample majority vote per bit, false-start rejection, framing-error and overrun reporting, and break handling. Frame format is fixed at 8N1, LSB first.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_rx_oversample.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: receiver states, oversampling
// constants and the 3-sample majority vote.
package uart_pkg;

  localparam int OVERSAMPLE    = 16;
  localparam int SAMPLE_LO     = 7;
  localparam int SAMPLE_MID    = 8;
  localparam int SAMPLE_HI     = 9;
  localparam int DEF_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } rx_state_t;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every TICK_DIV clocks,
// re-phased by a synchronous clear.
module uart_baud_tick #(
  parameter int TICK_DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Wrap at LAST; clr restarts the count so ticks align to it.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  // Divider state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling 8N1 UART receiver feeding a FIFO write port,
// with majority voting, false-start, framing, overrun and break handling.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int TICK_DIV  = 54,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 we,
  input  logic                 full,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [3:0] S_LO  = 4'(SAMPLE_LO);
  localparam logic [3:0] S_MID = 4'(SAMPLE_MID);
  localparam logic [3:0] S_HI  = 4'(SAMPLE_HI);
  localparam logic [3:0] S_END = 4'(OVERSAMPLE - 1);

  logic                 sync_q;
  logic                 din_s_q;
  logic                 dly_q;
  rx_state_t            state_q;
  logic [3:0]           samp_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] dout_q;
  logic                 s7_q;
  logic                 s8_q;
  logic                 we_q;
  logic                 fe_q;
  logic                 ov_q;
  logic                 busy_q;

  logic tick;
  logic fall;
  logic clr;
  logic maj;
  logic at_hi;
  logic at_end;

  assign fall   = dly_q & ~din_s_q;
  assign clr    = (state_q == IDLE) && fall;
  assign maj    = maj3(s7_q, s8_q, din_s_q);
  assign at_hi  = tick && (samp_q == S_HI);
  assign at_end = tick && (samp_q == S_END);

  uart_baud_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );

  // Two-flop synchroniser plus delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 1'b1;
      din_s_q <= 1'b1;
      dly_q   <= 1'b1;
    end else begin
      sync_q  <= din;
      din_s_q <= sync_q;
      dly_q   <= din_s_q;
    end
  end

  // Frame sequencer with registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      s7_q    <= 1'b1;
      s8_q    <= 1'b1;
      we_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
      if (state_q != IDLE && state_q != BRK && tick) begin
        samp_q <= samp_q + 4'd1;
        if (samp_q == S_LO) s7_q <= din_s_q;
        if (samp_q == S_MID) s8_q <= din_s_q;
      end
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= START;
            samp_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (at_hi && maj) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (at_end) begin
            state_q <= DATA;
            bit_q   <= '0;
          end
        end
        DATA: begin
          if (at_hi) begin
            shift_q <= {maj, shift_q[DATA_BITS-1:1]};
          end
          if (at_end) begin
            if (bit_q == LAST_BIT) begin
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end
        end
        STOP: begin
          if (at_hi) begin
            if (!maj) begin
              fe_q    <= 1'b1;
              state_q <= BRK;
            end else begin
              if (full) begin
                ov_q <= 1'b1;
              end else begin
                we_q   <= 1'b1;
                dout_q <= shift_q;
              end
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        BRK: begin
          if (din_s_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout      = dout_q;
  assign we        = we_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample at TICK_DIV=4
// (64 clk per bit), checked with immediate assertions.
module tb_uart_rx_oversample;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b1;
  logic       full = 1'b0;
  logic [7:0] dout;
  logic       we;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  int lat      = -1;
  int we_cnt   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int excl     = 0;
  logic [7:0] got[$];

  uart_rx_oversample #(
    .TICK_DIV (4),
    .DATA_BITS(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .dout     (dout),
    .we       (we),
    .full     (full),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) begin
      we_cnt++;
      got.push_back(dout);
      lat = cyc - t0;
    end
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (int'(we) + int'(frame_err) + int'(overrun) > 1) excl++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din = v;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop_v,
                      input int fslot, input int flo, input int fhi);
    logic [9:0] fr;
    fr = {stop_v, d, 1'b0};
    for (int s = 0; s < 10; s++) begin
      for (int j = 1; j <= 64; j++) begin
        @(negedge clk);
        if (s == 0 && j == 1) t0 = cyc;
        din = fr[s] ^ (s == fslot && j >= flo && j <= fhi);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    din = 1'b1;
    full = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_strobes", {29'd0, we, frame_err, overrun}, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    hold(1'b1, 20);

    send(8'h55, 1'b1, -1, 0, 0);
    chk("f55_we_cnt", 32'(we_cnt), 32'd1);
    chk("f55_dout", 32'(got[$]), 32'h55);
    chk("f55_lat_win", 32'(lat >= 612 && lat <= 626), 32'd1);
    chk("f55_busy", 32'(busy), 32'h0);
    chk("f55_fe_ov", 32'(fe_cnt + ov_cnt), 32'd0);
    hold(1'b1, 20);

    send(8'hA5, 1'b1, -1, 0, 0);
    send(8'h3C, 1'b1, -1, 0, 0);
    chk("b2b_we_cnt", 32'(we_cnt), 32'd3);
    chk("b2b_first", 32'(got[1]), 32'hA5);
    chk("b2b_second", 32'(got[2]), 32'h3C);
    hold(1'b1, 20);

    hold(1'b0, 8);
    chk("glitch_busy_hi", 32'(busy), 32'h1);
    hold(1'b0, 8);
    hold(1'b1, 32);
    chk("glitch_busy_lo", 32'(busy), 32'h0);
    chk("glitch_we_cnt", 32'(we_cnt), 32'd3);
    chk("glitch_fe", 32'(fe_cnt), 32'd0);
    hold(1'b1, 20);

    send(8'hFF, 1'b0, -1, 0, 0);
    hold(1'b0, 20 * 64);
    chk("brk_fe_cnt", 32'(fe_cnt), 32'd1);
    chk("brk_we_cnt", 32'(we_cnt), 32'd3);
    chk("brk_busy", 32'(busy), 32'h1);
    hold(1'b1, 10);
    chk("brk_release", 32'(busy), 32'h0);
    send(8'h12, 1'b1, -1, 0, 0);
    chk("after_brk_we", 32'(we_cnt), 32'd4);
    chk("after_brk_dout", 32'(got[$]), 32'h12);
    hold(1'b1, 20);

    send(8'h55, 1'b1, -1, 0, 0);
    hold(1'b1, 20);
    full = 1'b1;
    send(8'h7E, 1'b1, -1, 0, 0);
    full = 1'b0;
    chk("ovr_cnt", 32'(ov_cnt), 32'd1);
    chk("ovr_we_cnt", 32'(we_cnt), 32'd5);
    chk("ovr_dout", 32'(dout), 32'h55);
    chk("ovr_fe", 32'(fe_cnt), 32'd1);
    hold(1'b1, 20);

    send(8'h81, 1'b1, 4, 35, 39);
    chk("maj_we_cnt", 32'(we_cnt), 32'd6);
    chk("maj_dout", 32'(got[$]), 32'h81);
    hold(1'b1, 20);

    hold(1'b0, 64);
    hold(1'b1, 64);
    hold(1'b0, 30);
    @(negedge clk);
    rst = 1'b0;
    din = 1'b1;
    #1;
    chk("mid_rst_dout", 32'(dout), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_strb", {29'd0, we, frame_err, overrun}, 32'h0);
    hold(1'b1, 5);
    rst = 1'b1;
    hold(1'b1, 20);
    chk("post_rst_we", 32'(we_cnt), 32'd6);
    send(8'h81, 1'b1, -1, 0, 0);
    chk("post_rst_cnt", 32'(we_cnt), 32'd7);
    chk("post_rst_dout", 32'(got[$]), 32'h81);
    chk("post_rst_fe_ov", 32'(fe_cnt + ov_cnt), 32'd2);
    chk("exclusive", 32'(excl), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
